// File: rtl/gmii_udp_pkg.sv
// Shared constants for the GMII UDP demultiplexer: header byte offsets
// (index 0 = first preamble byte), payload type codes and FSM encoding.
package gmii_udp_pkg;

  localparam logic [10:0] OFS_ETHTYPE = 11'd20;
  localparam logic [10:0] OFS_IPVER   = 11'd22;
  localparam logic [10:0] OFS_PROTO   = 11'd31;
  localparam logic [10:0] OFS_DSTIP   = 11'd38;
  localparam logic [10:0] OFS_DSTPORT = 11'd44;
  localparam logic [10:0] OFS_UDPLEN  = 11'd46;
  localparam logic [10:0] OFS_TYPE    = 11'd50;
  localparam logic [10:0] OFS_UDP     = 11'd42;
  localparam logic [10:0] OFS_VHDR0   = 11'd51;
  localparam logic [10:0] OFS_VHDR1   = 11'd52;
  localparam logic [10:0] CNT_MAX     = 11'd2047;

  localparam logic [7:0] PT_VIDEO = 8'h00;
  localparam logic [7:0] PT_AUDIO = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_VHDR = 3'd2,
    ST_VPAY = 3'd3,
    ST_APAY = 3'd4,
    ST_DROP = 3'd5
  } state_e;

  // End-of-packet outcome recorded for the optional statistics counters.
  typedef enum logic [1:0] {
    OC_NONE = 2'd0,
    OC_OK   = 2'd1,
    OC_DROP = 2'd2,
    OC_OVF  = 2'd3
  } outcome_e;

  // True while an accepted packet's payload is being processed.
  function automatic logic is_payload(input state_e s);
    return (s == ST_VHDR) || (s == ST_VPAY) || (s == ST_APAY);
  endfunction

endpackage

// File: rtl/gmii_udp_demux_hdr_filter.sv
// Byte counter, header field capture and accept filter for gmii_udp_demux.
// All outputs except the captured header state are combinational decodes of
// the current byte position; the parent FSM qualifies them by state.
module gmii_hdr_filter
  import gmii_udp_pkg::*;
#(
  parameter logic [31:0] IPV4_DST_BASE = 32'hC0A80001,
  parameter logic [15:0] DST_PORT      = 16'd12345,
  parameter logic [15:0] ETH_TYPE      = 16'h0800,
  parameter logic [7:0]  IP_VER        = 8'h45,
  parameter logic [7:0]  IP_PROTO      = 8'h11,
  parameter int          NUM_CH        = 2
) (
  input  logic        clk125,
  input  logic        sys_rst_n,
  input  logic        id,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  output logic        byte_vld_o,
  output logic [10:0] rx_cnt_o,
  output logic        hdr_ok_o,
  output logic [2:0]  ch_o,
  output logic        last_o,
  output logic        sat_o
);

  logic        arm_q;
  logic [10:0] rx_cnt_q;
  logic [15:0] eth_type_q;
  logic [7:0]  ip_ver_q;
  logic [7:0]  proto_q;
  logic [31:0] dst_ip_q;
  logic [15:0] dst_port_q;
  logic [15:0] udp_len_q;

  logic [7:0]  base_s;
  logic [7:0]  ch_s;
  logic [16:0] last_idx_s;

  // After reset, bytes are only counted once rx_dv has been seen low, so a
  // frame already in flight at reset release is ignored entirely.
  assign byte_vld_o = rx_dv & arm_q;

  // Arm flag and saturating byte counter; counter clears while rx_dv is low.
  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      arm_q    <= 1'b0;
      rx_cnt_q <= 11'd0;
    end else begin
      arm_q <= arm_q | ~rx_dv;
      if (byte_vld_o) begin
        rx_cnt_q <= (rx_cnt_q == CNT_MAX) ? rx_cnt_q : rx_cnt_q + 11'd1;
      end else begin
        rx_cnt_q <= 11'd0;
      end
    end
  end

  // Big-endian capture of the header fields used by the filter.
  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      eth_type_q <= 16'd0;
      ip_ver_q   <= 8'd0;
      proto_q    <= 8'd0;
      dst_ip_q   <= 32'd0;
      dst_port_q <= 16'd0;
      udp_len_q  <= 16'd0;
    end else if (byte_vld_o) begin
      case (rx_cnt_q)
        OFS_ETHTYPE:          eth_type_q[15:8] <= rxd;
        OFS_ETHTYPE + 11'd1:  eth_type_q[7:0]  <= rxd;
        OFS_IPVER:            ip_ver_q         <= rxd;
        OFS_PROTO:            proto_q          <= rxd;
        OFS_DSTIP:            dst_ip_q[31:24]  <= rxd;
        OFS_DSTIP + 11'd1:    dst_ip_q[23:16]  <= rxd;
        OFS_DSTIP + 11'd2:    dst_ip_q[15:8]   <= rxd;
        OFS_DSTIP + 11'd3:    dst_ip_q[7:0]    <= rxd;
        OFS_DSTPORT:          dst_port_q[15:8] <= rxd;
        OFS_DSTPORT + 11'd1:  dst_port_q[7:0]  <= rxd;
        OFS_UDPLEN:           udp_len_q[15:8]  <= rxd;
        OFS_UDPLEN + 11'd1:   udp_len_q[7:0]   <= rxd;
        default: ;
      endcase
    end else begin
      udp_len_q <= udp_len_q;
    end
  end

  // Channel window starts at the base host byte, shifted by NUM_CH per board.
  assign base_s = IPV4_DST_BASE[7:0] + (id ? 8'(NUM_CH) : 8'd0);
  assign ch_s   = dst_ip_q[7:0] - base_s;
  assign ch_o   = ch_s[2:0];

  assign hdr_ok_o = (eth_type_q == ETH_TYPE) &&
                    (ip_ver_q == IP_VER) &&
                    (proto_q == IP_PROTO) &&
                    (dst_ip_q[31:8] == IPV4_DST_BASE[31:8]) &&
                    (ch_s < 8'(NUM_CH)) &&
                    (dst_port_q == DST_PORT) &&
                    (udp_len_q >= 16'd11);

  // UDP length covers its own 8-byte header, which starts at OFS_UDP.
  assign last_idx_s = 17'(OFS_UDP) - 17'd1 + {1'b0, udp_len_q};
  assign last_o     = byte_vld_o && (last_idx_s == {6'd0, rx_cnt_q});
  assign sat_o      = (rx_cnt_q == CNT_MAX);
  assign rx_cnt_o   = rx_cnt_q;

endmodule

// File: rtl/gmii_udp_demux.sv
// GMII Ethernet/IPv4/UDP receiver that demuxes payload into a video FIFO
// stream (pixel words tagged with line/x_tag) and a 12-bit AUX FIFO stream.
// Optional statistics counters: define GMII_UDP_DEMUX_STATS_EN.
module gmii_udp_demux
  import gmii_udp_pkg::*;
#(
  parameter logic [31:0] IPV4_DST_BASE = 32'hC0A80001,
  parameter logic [15:0] DST_PORT      = 16'd12345,
  parameter logic [15:0] ETH_TYPE      = 16'h0800,
  parameter logic [7:0]  IP_VER        = 8'h45,
  parameter logic [7:0]  IP_PROTO      = 8'h11,
  parameter int          NUM_CH        = 2,
  parameter int          PIX_BYTES     = 2,
  parameter int          VID_W         = 16 + 8 * PIX_BYTES
) (
  input  logic             clk125,
  input  logic             sys_rst_n,
  input  logic             id,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  output logic [VID_W-1:0] vid_data,
  output logic             vid_wr_en,
  input  logic             vid_full,
  output logic [2:0]       vid_ch,
  output logic [11:0]      aux_data,
  output logic             aux_wr_en,
  input  logic             aux_full,
  output logic             pkt_active,
  output logic             ovf_err
`ifdef GMII_UDP_DEMUX_STATS_EN
  ,
  output logic [15:0]      pkt_ok_cnt,
  output logic [15:0]      pkt_drop_cnt,
  output logic [15:0]      ovf_cnt
`endif
);

  localparam int         PW       = 8 * PIX_BYTES;
  localparam logic [1:0] PIX_LAST = 2'(PIX_BYTES - 1);

  logic        byte_vld_s;
  logic [10:0] rx_cnt_s;
  logic        hdr_ok_s;
  logic [2:0]  ch_s;
  logic        last_s;
  logic        sat_s;
  logic        end_s;
  logic        abort_s;
  logic [PW-1:0] pix_word_s;

  state_e           state_q,    state_d;
  logic [VID_W-1:0] vid_data_q, vid_data_d;
  logic             vid_wr_q,   vid_wr_d;
  logic [2:0]       vid_ch_q,   vid_ch_d;
  logic [11:0]      aux_data_q, aux_data_d;
  logic             aux_wr_q,   aux_wr_d;
  logic             ovf_q,      ovf_d;
  logic [11:0]      y_q,        y_d;
  logic [3:0]       xtag_q,     xtag_d;
  logic [PW-9:0]    pix_acc_q,  pix_acc_d;
  logic [1:0]       pix_idx_q,  pix_idx_d;
  logic [1:0]       grp_q,      grp_d;
  logic [7:0]       aux_b0_q,   aux_b0_d;
  logic [3:0]       aux_hi_q,   aux_hi_d;

  gmii_hdr_filter #(
    .IPV4_DST_BASE (IPV4_DST_BASE),
    .DST_PORT      (DST_PORT),
    .ETH_TYPE      (ETH_TYPE),
    .IP_VER        (IP_VER),
    .IP_PROTO      (IP_PROTO),
    .NUM_CH        (NUM_CH)
  ) u_filter (
    .clk125     (clk125),
    .sys_rst_n  (sys_rst_n),
    .id         (id),
    .rxd        (rxd),
    .rx_dv      (rx_dv),
    .byte_vld_o (byte_vld_s),
    .rx_cnt_o   (rx_cnt_s),
    .hdr_ok_o   (hdr_ok_s),
    .ch_o       (ch_s),
    .last_o     (last_s),
    .sat_o      (sat_s)
  );

  // Payload ends on the last UDP byte, or when an oversize frame saturates.
  assign end_s      = last_s | sat_s;
  assign pix_word_s = {pix_acc_q, rxd};

  // Next-state, packers and write strobes; writes land one cycle after the
  // completing byte, and a full FIFO seen on that byte aborts the packet.
  always_comb begin
    state_d    = state_q;
    vid_data_d = vid_data_q;
    vid_wr_d   = 1'b0;
    vid_ch_d   = vid_ch_q;
    aux_data_d = aux_data_q;
    aux_wr_d   = 1'b0;
    ovf_d      = 1'b0;
    y_d        = y_q;
    xtag_d     = xtag_q;
    pix_acc_d  = pix_acc_q;
    pix_idx_d  = pix_idx_q;
    grp_d      = grp_q;
    aux_b0_d   = aux_b0_q;
    aux_hi_d   = aux_hi_q;
    abort_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_vld_s && (rx_cnt_s == 11'd0)) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HDR: begin
        if (!byte_vld_s) begin
          state_d = ST_IDLE;
        end else if (rx_cnt_s == OFS_TYPE) begin
          pix_idx_d = 2'd0;
          grp_d     = 2'd0;
          if (hdr_ok_s && (rxd == PT_VIDEO)) begin
            state_d  = ST_VHDR;
            vid_ch_d = ch_s;
          end else if (hdr_ok_s && (rxd == PT_AUDIO)) begin
            state_d  = ST_APAY;
            vid_ch_d = ch_s;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          state_d = ST_HDR;
        end
      end

      ST_VHDR: begin
        if (!byte_vld_s) begin
          state_d = ST_IDLE;
        end else begin
          if (rx_cnt_s == OFS_VHDR0) begin
            y_d[7:0] = rxd;
          end else begin
            y_d[11:8] = rxd[3:0];
            xtag_d    = rxd[7:4];
          end
          if (end_s) begin
            state_d = ST_DROP;
          end else if (rx_cnt_s == OFS_VHDR1) begin
            state_d = ST_VPAY;
          end else begin
            state_d = ST_VHDR;
          end
        end
      end

      ST_VPAY: begin
        if (!byte_vld_s) begin
          state_d = ST_IDLE;
        end else begin
          if (pix_idx_q == PIX_LAST) begin
            pix_idx_d = 2'd0;
            if (vid_full) begin
              ovf_d   = 1'b1;
              abort_s = 1'b1;
            end else begin
              vid_wr_d   = 1'b1;
              vid_data_d = {xtag_q, y_q, pix_word_s};
            end
          end else begin
            pix_acc_d = pix_word_s[PW-9:0];
            pix_idx_d = pix_idx_q + 2'd1;
          end
          if (abort_s || end_s) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_VPAY;
          end
        end
      end

      ST_APAY: begin
        if (!byte_vld_s) begin
          state_d = ST_IDLE;
        end else begin
          case (grp_q)
            2'd0: begin
              aux_b0_d = rxd;
              grp_d    = 2'd1;
            end
            2'd1: begin
              aux_hi_d = rxd[7:4];
              grp_d    = 2'd2;
              if (aux_full) begin
                ovf_d   = 1'b1;
                abort_s = 1'b1;
              end else begin
                aux_wr_d   = 1'b1;
                aux_data_d = {rxd[3:0], aux_b0_q};
              end
            end
            default: begin
              grp_d = 2'd0;
              if (aux_full) begin
                ovf_d   = 1'b1;
                abort_s = 1'b1;
              end else begin
                aux_wr_d   = 1'b1;
                aux_data_d = {rxd, aux_hi_q};
              end
            end
          endcase
          if (abort_s || end_s) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_APAY;
          end
        end
      end

      ST_DROP: begin
        if (!byte_vld_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      vid_data_q <= '0;
      vid_wr_q   <= 1'b0;
      vid_ch_q   <= 3'd0;
      aux_data_q <= 12'd0;
      aux_wr_q   <= 1'b0;
      ovf_q      <= 1'b0;
      y_q        <= 12'd0;
      xtag_q     <= 4'd0;
      pix_acc_q  <= '0;
      pix_idx_q  <= 2'd0;
      grp_q      <= 2'd0;
      aux_b0_q   <= 8'd0;
      aux_hi_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      vid_data_q <= vid_data_d;
      vid_wr_q   <= vid_wr_d;
      vid_ch_q   <= vid_ch_d;
      aux_data_q <= aux_data_d;
      aux_wr_q   <= aux_wr_d;
      ovf_q      <= ovf_d;
      y_q        <= y_d;
      xtag_q     <= xtag_d;
      pix_acc_q  <= pix_acc_d;
      pix_idx_q  <= pix_idx_d;
      grp_q      <= grp_d;
      aux_b0_q   <= aux_b0_d;
      aux_hi_q   <= aux_hi_d;
    end
  end

  assign vid_data   = vid_data_q;
  assign vid_wr_en  = vid_wr_q;
  assign vid_ch     = vid_ch_q;
  assign aux_data   = aux_data_q;
  assign aux_wr_en  = aux_wr_q;
  assign ovf_err    = ovf_q;
  assign pkt_active = is_payload(state_q);

`ifdef GMII_UDP_DEMUX_STATS_EN
  outcome_e    outcome_q, outcome_d;
  logic [15:0] ok_cnt_q, drop_cnt_q, ovf_cnt_q;

  // Remember how the current packet ended; truncated packets record nothing.
  always_comb begin
    outcome_d = outcome_q;
    if (!byte_vld_s) begin
      outcome_d = OC_NONE;
    end else if ((state_q == ST_HDR) && (state_d == ST_DROP)) begin
      outcome_d = OC_DROP;
    end else if (ovf_d) begin
      outcome_d = OC_OVF;
    end else if (is_payload(state_q) && last_s && (state_d == ST_DROP)) begin
      outcome_d = OC_OK;
    end else begin
      outcome_d = outcome_q;
    end
  end

  // Commit the recorded outcome to its counter once rx_dv drops.
  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      outcome_q  <= OC_NONE;
      ok_cnt_q   <= 16'd0;
      drop_cnt_q <= 16'd0;
      ovf_cnt_q  <= 16'd0;
    end else begin
      outcome_q <= outcome_d;
      if (!byte_vld_s) begin
        case (outcome_q)
          OC_OK:   ok_cnt_q   <= ok_cnt_q + 16'd1;
          OC_DROP: drop_cnt_q <= drop_cnt_q + 16'd1;
          OC_OVF:  ovf_cnt_q  <= ovf_cnt_q + 16'd1;
          default: ;
        endcase
      end else begin
        ok_cnt_q <= ok_cnt_q;
      end
    end
  end

  assign pkt_ok_cnt   = ok_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
  assign ovf_cnt      = ovf_cnt_q;
`endif

endmodule
